// File: rtl/usb_pkg.sv
// usb_pkg: shared constants for the USB full-speed transmit path.
// Holds PID nibbles, the handshake-code encoding and the packet
// scheduler state enum, plus helpers that form PID bytes.
package usb_pkg;

  // PID nibbles as they appear in the low half of the PID byte
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;

  // hs_code encoding; the spare code 11 is sent as STALL
  localparam logic [1:0] HS_ACK   = 2'b00;
  localparam logic [1:0] HS_NAK   = 2'b01;
  localparam logic [1:0] HS_STALL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_PAYLOAD,
    S_DRAIN,
    S_GAP
  } sched_state_t;

  // PID byte carries the complement of the nibble in its upper half
  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

  // Map a handshake code to its PID nibble
  function automatic logic [3:0] hs_pid(input logic [1:0] code);
    logic [3:0] pid;
    case (code)
      HS_ACK:  pid = PID_ACK;
      HS_NAK:  pid = PID_NAK;
      default: pid = PID_STALL;
    endcase
    return pid;
  endfunction

endpackage

// File: rtl/usb_tx_sched_stats.sv
// usb_tx_sched_stats: free-running counters of completed handshakes and
// data packets. Only compiled when USB_TX_SCHED_STATS_EN is defined, so
// the default build carries no stray top-level module.
`ifdef USB_TX_SCHED_STATS_EN
module usb_tx_sched_stats (
  input  logic        clk_48,
  input  logic        rst_n,
  input  logic        hs_ack,
  input  logic        dp_done,
  output logic [15:0] stat_hs_cnt,
  output logic [15:0] stat_dp_cnt
);

  logic [15:0] hs_cnt_reg;
  logic [15:0] dp_cnt_reg;

  // Count completion pulses; both counters wrap naturally at 16 bits
  always_ff @(posedge clk_48) begin
    if (!rst_n) begin
      hs_cnt_reg <= 16'd0;
      dp_cnt_reg <= 16'd0;
    end else begin
      if (hs_ack) begin
        hs_cnt_reg <= hs_cnt_reg + 16'd1;
      end
      if (dp_done) begin
        dp_cnt_reg <= dp_cnt_reg + 16'd1;
      end
    end
  end

  assign stat_hs_cnt = hs_cnt_reg;
  assign stat_dp_cnt = dp_cnt_reg;

endmodule
`endif

// File: rtl/usb_tx_sched.sv
// usb_tx_sched: packet sequencer/arbiter and sole master of usb_tx.
// Sends ACK/NAK/STALL handshakes and DATA0/DATA1 packets (handshake wins
// ties), forms the PID byte, steers CRC16 update/append and enforces the
// inter-packet gap after tx_en falls.
// Optional: define USB_TX_SCHED_STATS_EN to add stat_hs_cnt/stat_dp_cnt.
module usb_tx_sched
  import usb_pkg::*;
#(
  parameter int MAX_PKT  = 64,
  parameter int LEN_W    = 7,
  parameter int IPG_CLKS = 8
) (
  input  logic             clk_48,
  input  logic             rst_n,
  input  logic             hs_req,
  input  logic [1:0]       hs_code,
  output logic             hs_ack,
  input  logic             dp_req,
  input  logic             dp_data1,
  input  logic [LEN_W-1:0] dp_len,
  input  logic [7:0]       dp_byte,
  output logic             dp_rd,
  output logic             dp_done,
`ifdef USB_TX_SCHED_STATS_EN
  output logic [15:0]      stat_hs_cnt,
  output logic [15:0]      stat_dp_cnt,
`endif
  output logic             tx_transmit,
  output logic [7:0]       tx_data,
  output logic             tx_update_crc16,
  output logic             tx_send_crc16,
  input  logic             tx_data_strobe,
  input  logic             tx_en
);

  localparam int               GAP_W    = (IPG_CLKS > 1) ? $clog2(IPG_CLKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IPG_CLKS - 1);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_PKT);

  sched_state_t     state_reg, state_next;
  logic             is_hs_reg, is_hs_next;
  logic [LEN_W-1:0] remain_reg, remain_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic             tx_transmit_reg, tx_transmit_next;
  logic [7:0]       tx_data_reg, tx_data_next;
  logic             tx_update_crc16_reg, tx_update_crc16_next;
  logic             tx_send_crc16_reg, tx_send_crc16_next;
  logic             hs_ack_reg, hs_ack_next;
  logic             dp_done_reg, dp_done_next;
  logic [LEN_W-1:0] len_clamped;

  // Oversized requests are truncated to the endpoint's maximum packet size
  assign len_clamped = (dp_len > MAX_LEN) ? MAX_LEN : dp_len;

  // State and output registers; reset abandons any in-flight packet silently
  always_ff @(posedge clk_48) begin
    if (!rst_n) begin
      state_reg           <= S_IDLE;
      is_hs_reg           <= 1'b0;
      remain_reg          <= '0;
      gap_reg             <= '0;
      tx_transmit_reg     <= 1'b0;
      tx_data_reg         <= 8'h00;
      tx_update_crc16_reg <= 1'b0;
      tx_send_crc16_reg   <= 1'b0;
      hs_ack_reg          <= 1'b0;
      dp_done_reg         <= 1'b0;
    end else begin
      state_reg           <= state_next;
      is_hs_reg           <= is_hs_next;
      remain_reg          <= remain_next;
      gap_reg             <= gap_next;
      tx_transmit_reg     <= tx_transmit_next;
      tx_data_reg         <= tx_data_next;
      tx_update_crc16_reg <= tx_update_crc16_next;
      tx_send_crc16_reg   <= tx_send_crc16_next;
      hs_ack_reg          <= hs_ack_next;
      dp_done_reg         <= dp_done_next;
    end
  end

  // Next-state and serializer-handshake logic; dp_rd is the only combinational output
  always_comb begin
    state_next           = state_reg;
    is_hs_next           = is_hs_reg;
    remain_next          = remain_reg;
    gap_next             = gap_reg;
    tx_transmit_next     = tx_transmit_reg;
    tx_data_next         = tx_data_reg;
    tx_update_crc16_next = tx_update_crc16_reg;
    tx_send_crc16_next   = tx_send_crc16_reg;
    hs_ack_next          = 1'b0;
    dp_done_next         = 1'b0;
    dp_rd                = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (hs_req) begin
          is_hs_next           = 1'b1;
          remain_next          = '0;
          tx_data_next         = pid_byte(hs_pid(hs_code));
          tx_send_crc16_next   = 1'b0;
          tx_update_crc16_next = 1'b0;
          tx_transmit_next     = 1'b1;
          state_next           = S_PID;
        end else if (dp_req) begin
          is_hs_next           = 1'b0;
          remain_next          = len_clamped;
          tx_data_next         = pid_byte(dp_data1 ? PID_DATA1 : PID_DATA0);
          tx_send_crc16_next   = 1'b1;
          tx_update_crc16_next = 1'b0;
          tx_transmit_next     = 1'b1;
          state_next           = S_PID;
        end
      end

      S_PID, S_PAYLOAD: begin
        // Each strobe means usb_tx took the current byte; offer the next one or stop
        if (tx_data_strobe) begin
          if (remain_reg != '0) begin
            dp_rd                = 1'b1;
            tx_data_next         = dp_byte;
            remain_next          = remain_reg - 1'b1;
            tx_update_crc16_next = 1'b1;
            state_next           = S_PAYLOAD;
          end else begin
            tx_transmit_next = 1'b0;
            state_next       = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        // CRC append flag must stay up until usb_tx has finished CRC and EOP
        if (!tx_en) begin
          hs_ack_next          = is_hs_reg;
          dp_done_next         = !is_hs_reg;
          tx_send_crc16_next   = 1'b0;
          tx_update_crc16_next = 1'b0;
          gap_next             = GAP_LOAD;
          state_next           = S_GAP;
        end
      end

      S_GAP: begin
        if (gap_reg == '0) begin
          state_next = S_IDLE;
        end else begin
          gap_next = gap_reg - 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign tx_transmit     = tx_transmit_reg;
  assign tx_data         = tx_data_reg;
  assign tx_update_crc16 = tx_update_crc16_reg;
  assign tx_send_crc16   = tx_send_crc16_reg;
  assign hs_ack          = hs_ack_reg;
  assign dp_done         = dp_done_reg;

`ifdef USB_TX_SCHED_STATS_EN
  usb_tx_sched_stats u_stats (
    .clk_48      (clk_48),
    .rst_n       (rst_n),
    .hs_ack      (hs_ack_reg),
    .dp_done     (dp_done_reg),
    .stat_hs_cnt (stat_hs_cnt),
    .stat_dp_cnt (stat_dp_cnt)
  );
`endif

endmodule

// File: tb/tb_usb_tx_sched.sv
// tb_usb_tx_sched: scoreboard bench for usb_tx_sched with a behavioural
// usb_tx model (sync, byte strobes, CRC, EOP). Expected bytes/packets are
// queued when a request is driven and popped as the model takes bytes.
module tb_usb_tx_sched;

  localparam int MAX_PKT   = 64;
  localparam int LEN_W     = 7;
  localparam int IPG_CLKS  = 8;
  localparam int BYTE_CLKS = 32;
  localparam int EOP_CLKS  = 12;
  localparam int BUDGET    = 8000;

  logic             clk_48;
  logic             rst_n;
  logic             hs_req;
  logic [1:0]       hs_code;
  logic             hs_ack;
  logic             dp_req;
  logic             dp_data1;
  logic [LEN_W-1:0] dp_len;
  logic [7:0]       dp_byte;
  logic             dp_rd;
  logic             dp_done;
  logic             tx_transmit;
  logic [7:0]       tx_data;
  logic             tx_update_crc16;
  logic             tx_send_crc16;
  logic             tx_data_strobe;
  logic             tx_en;
`ifdef USB_TX_SCHED_STATS_EN
  logic [15:0]      stat_hs_cnt;
  logic [15:0]      stat_dp_cnt;
`endif

  usb_tx_sched #(.MAX_PKT(MAX_PKT), .LEN_W(LEN_W), .IPG_CLKS(IPG_CLKS)) dut (
    .clk_48          (clk_48),
    .rst_n           (rst_n),
    .hs_req          (hs_req),
    .hs_code         (hs_code),
    .hs_ack          (hs_ack),
    .dp_req          (dp_req),
    .dp_data1        (dp_data1),
    .dp_len          (dp_len),
    .dp_byte         (dp_byte),
    .dp_rd           (dp_rd),
    .dp_done         (dp_done),
`ifdef USB_TX_SCHED_STATS_EN
    .stat_hs_cnt     (stat_hs_cnt),
    .stat_dp_cnt     (stat_dp_cnt),
`endif
    .tx_transmit     (tx_transmit),
    .tx_data         (tx_data),
    .tx_update_crc16 (tx_update_crc16),
    .tx_send_crc16   (tx_send_crc16),
    .tx_data_strobe  (tx_data_strobe),
    .tx_en           (tx_en)
  );

  initial clk_48 = 1'b0;
  always #5 clk_48 = ~clk_48;

  typedef struct { logic [7:0] data; logic upd; } exp_byte_t;
  typedef struct { logic send_crc; int nbytes; } exp_pkt_t;

  exp_byte_t  exp_byte_q[$];
  exp_pkt_t   exp_pkt_q[$];
  logic [7:0] src_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int idle_clks = 0;
  bit pop_pending = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string pfx);
    check_val({pfx, "_tx_transmit"}, tx_transmit, 0);
    check_val({pfx, "_tx_data"}, tx_data, 0);
    check_val({pfx, "_tx_update_crc16"}, tx_update_crc16, 0);
    check_val({pfx, "_tx_send_crc16"}, tx_send_crc16, 0);
    check_val({pfx, "_hs_ack"}, hs_ack, 0);
    check_val({pfx, "_dp_done"}, dp_done, 0);
    check_val({pfx, "_dp_rd"}, dp_rd, 0);
  endtask

  // Event counters sampled mid-cycle, away from the active edge
  initial begin : monitor
    forever begin
      @(negedge clk_48);
      if (dp_rd) begin
        rd_cnt++;
        pop_pending = 1'b1;
      end
      if (hs_ack) ack_cnt++;
      if (dp_done) done_cnt++;
    end
  end

  // Show-ahead byte source: pops after the edge at which dp_rd was seen
  initial begin : byte_source
    dp_byte = 8'h00;
    forever begin
      @(posedge clk_48); #1;
      if (pop_pending) begin
        if (src_q.size() != 0) void'(src_q.pop_front());
        pop_pending = 1'b0;
      end
      dp_byte = (src_q.size() != 0) ? src_q[0] : 8'h00;
    end
  end

  task automatic tx_wait(input int n, output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_48); #1;
      if (!rst_n) begin
        aborted = 1'b1;
        return;
      end
    end
  endtask

  // One packet of the usb_tx model: sync, strobe per byte, optional CRC, EOP
  task automatic model_packet();
    exp_byte_t e;
    exp_pkt_t  p;
    int        nb;
    bit        ab;
    logic      sc;
    check_val("ipg_gap", idle_clks >= IPG_CLKS, 1);
    tx_en = 1'b1;
    nb = 0;
    tx_wait(BYTE_CLKS, ab);
    while (!ab && tx_transmit) begin
      tx_data_strobe = 1'b1;
      if (exp_byte_q.size() == 0) begin
        check_val("byte_unexpected", tx_data, 32'h100);
      end else begin
        e = exp_byte_q.pop_front();
        check_val("tx_data", tx_data, e.data);
        check_val("tx_update_crc16", tx_update_crc16, e.upd);
      end
      nb++;
      tx_wait(1, ab);
      tx_data_strobe = 1'b0;
      if (!ab) tx_wait(BYTE_CLKS - 1, ab);
    end
    if (!ab) begin
      sc = tx_send_crc16;
      if (exp_pkt_q.size() == 0) begin
        check_val("pkt_unexpected", exp_pkt_q.size(), 1);
      end else begin
        p = exp_pkt_q.pop_front();
        check_val("send_crc16", sc, p.send_crc);
        check_val("strobes_per_pkt", nb, p.nbytes);
        if (sc) tx_wait(2 * BYTE_CLKS, ab);
        if (!ab) check_val("send_crc16_hold", tx_send_crc16, p.send_crc);
      end
      if (!ab) tx_wait(EOP_CLKS, ab);
    end
    tx_en = 1'b0;
    tx_data_strobe = 1'b0;
    idle_clks = 0;
  endtask

  initial begin : usb_tx_model
    tx_en = 1'b0;
    tx_data_strobe = 1'b0;
    forever begin
      @(posedge clk_48); #1;
      if (rst_n && tx_transmit) model_packet();
      else idle_clks++;
    end
  end

  task automatic wait_for(input string tag, input int which, input int target);
    int cur;
    for (int i = 0; i < BUDGET; i++) begin
      cur = (which == 0) ? ack_cnt : (which == 1) ? done_cnt : rd_cnt;
      if (cur >= target) return;
      @(posedge clk_48); #1;
    end
    check_val(tag, 0, 1);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_48);
    #1;
  endtask

  task automatic do_hs(input logic [1:0] code, input logic [7:0] pid);
    int a0, r0, d0;
    exp_byte_q.push_back('{data: pid, upd: 1'b0});
    exp_pkt_q.push_back('{send_crc: 1'b0, nbytes: 1});
    a0 = ack_cnt; r0 = rd_cnt; d0 = done_cnt;
    hs_code = code;
    hs_req = 1'b1;
    wait_clks(1);
    check_val("hs_latency_transmit", tx_transmit, 1);
    wait_for("hs_ack_timeout", 0, a0 + 1);
    hs_req = 1'b0;
    wait_clks(IPG_CLKS + 8);
    check_val("hs_ack_pulses", ack_cnt - a0, 1);
    check_val("hs_no_dp_rd", rd_cnt - r0, 0);
    check_val("hs_no_dp_done", done_cnt - d0, 0);
    check_val("hs_bytes_left", exp_byte_q.size(), 0);
    $display("hs code=%b pid=0x%02h done", code, pid);
  endtask

  task automatic do_dp(input logic data1, input int len, input int nsrc,
                       input logic [7:0] seed, input logic [7:0] pid);
    int a0, r0, d0, n;
    n = (len > MAX_PKT) ? MAX_PKT : len;
    for (int i = 0; i < nsrc; i++) src_q.push_back(8'(int'(seed) + i));
    exp_byte_q.push_back('{data: pid, upd: 1'b0});
    for (int i = 0; i < n; i++) exp_byte_q.push_back('{data: 8'(int'(seed) + i), upd: 1'b1});
    exp_pkt_q.push_back('{send_crc: 1'b1, nbytes: n + 1});
    a0 = ack_cnt; r0 = rd_cnt; d0 = done_cnt;
    dp_data1 = data1;
    dp_len = LEN_W'(len);
    dp_req = 1'b1;
    wait_clks(1);
    check_val("dp_latency_transmit", tx_transmit, 1);
    wait_for("dp_done_timeout", 1, d0 + 1);
    dp_req = 1'b0;
    wait_clks(IPG_CLKS + 8);
    check_val("dp_rd_pulses", rd_cnt - r0, n);
    check_val("dp_done_pulses", done_cnt - d0, 1);
    check_val("dp_no_hs_ack", ack_cnt - a0, 0);
    check_val("dp_bytes_left", exp_byte_q.size(), 0);
    src_q.delete();
    $display("dp data1=%0d len=%0d pid=0x%02h rd=%0d done", data1, len, pid, rd_cnt - r0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int a0, r0, d0;
    rst_n = 1'b0; hs_req = 1'b0; hs_code = 2'b00;
    dp_req = 1'b0; dp_data1 = 1'b0; dp_len = '0;
    wait_clks(2);
    check_outputs_zero("reset");
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(12);

    do_hs(2'b00, 8'hD2);
    do_dp(1'b1, 3, 3, 8'h01, 8'h4B);
    do_dp(1'b0, 0, 0, 8'h00, 8'hC3);

    // Simultaneous NAK and DATA0: handshake must go first, then gap, then data
    exp_byte_q.push_back('{data: 8'h5A, upd: 1'b0});
    exp_byte_q.push_back('{data: 8'hC3, upd: 1'b0});
    exp_byte_q.push_back('{data: 8'hA0, upd: 1'b1});
    exp_byte_q.push_back('{data: 8'hA1, upd: 1'b1});
    exp_pkt_q.push_back('{send_crc: 1'b0, nbytes: 1});
    exp_pkt_q.push_back('{send_crc: 1'b1, nbytes: 3});
    src_q.push_back(8'hA0);
    src_q.push_back(8'hA1);
    a0 = ack_cnt; r0 = rd_cnt; d0 = done_cnt;
    hs_code = 2'b01; hs_req = 1'b1;
    dp_data1 = 1'b0; dp_len = LEN_W'(2); dp_req = 1'b1;
    wait_clks(1);
    check_val("both_first_pid", tx_data, 8'h5A);
    for (int i = 0; i < 2 * BUDGET; i++) begin
      if (ack_cnt > a0) hs_req = 1'b0;
      if (done_cnt > d0) break;
      wait_clks(1);
    end
    check_val("both_done_seen", done_cnt - d0, 1);
    hs_req = 1'b0; dp_req = 1'b0;
    wait_clks(IPG_CLKS + 8);
    check_val("both_ack_pulses", ack_cnt - a0, 1);
    check_val("both_dp_rd", rd_cnt - r0, 2);
    check_val("both_bytes_left", exp_byte_q.size(), 0);
    src_q.delete();
    $display("nak+data0 same cycle done");

    // Oversized request clamps to MAX_PKT
    do_dp(1'b1, 100, 100, 8'h40, 8'h4B);

    // Reset in the middle of a payload
    src_q.delete();
    for (int i = 0; i < 10; i++) src_q.push_back(8'(16 + i));
    exp_byte_q.push_back('{data: 8'hC3, upd: 1'b0});
    for (int i = 0; i < 10; i++) exp_byte_q.push_back('{data: 8'(16 + i), upd: 1'b1});
    exp_pkt_q.push_back('{send_crc: 1'b1, nbytes: 11});
    a0 = ack_cnt; r0 = rd_cnt; d0 = done_cnt;
    dp_data1 = 1'b0; dp_len = LEN_W'(10); dp_req = 1'b1;
    wait_for("midrst_wait_rd", 2, r0 + 3);
    rst_n = 1'b0;
    dp_req = 1'b0;
    wait_clks(1);
    check_outputs_zero("midrst");
    exp_byte_q.delete(); exp_pkt_q.delete(); src_q.delete();
    wait_clks(3);
    rst_n = 1'b1;
    exp_byte_q.delete(); exp_pkt_q.delete(); src_q.delete();
    wait_clks(24);
    check_val("midrst_no_done", done_cnt - d0, 0);
    check_val("midrst_no_ack", ack_cnt - a0, 0);
    check_val("midrst_transmit_idle", tx_transmit, 0);
    $display("reset mid-payload after %0d pops", rd_cnt - r0);

    // Recovery, and code 11 sent as STALL
    do_hs(2'b11, 8'h1E);

`ifdef USB_TX_SCHED_STATS_EN
    do_hs(2'b10, 8'h1E);
    do_dp(1'b0, 0, 0, 8'h00, 8'hC3);
    check_val("stat_hs_cnt", stat_hs_cnt, 2);
    check_val("stat_dp_cnt", stat_dp_cnt, 1);
    force dut.u_stats.hs_cnt_reg = 16'hFFFF;
    wait_clks(1);
    release dut.u_stats.hs_cnt_reg;
    wait_clks(1);
    check_val("stat_hs_preload", stat_hs_cnt, 16'hFFFF);
    do_hs(2'b00, 8'hD2);
    check_val("stat_hs_wrap", stat_hs_cnt, 0);
    check_val("stat_dp_after_wrap", stat_dp_cnt, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
